sample_framer: RTL and testbench
================================

SAMPLE_FRAMER -- requirements
Module: sample_framer

Interface
REQ-001 Parameter CLK_DIV, default 2500, clocks per sample period (20 kHz at 50 MHz); legal range 16..65535.
REQ-002 Parameter FRAME_LEN, default 256, samples per frame; must be a power of two.
REQ-003 Parameter ADDR_W, default 8, equals log2(FRAME_LEN).
REQ-004 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-005 clk  input  1  system clock; all logic on its rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 enable  input  1  high allows new sample requests.
REQ-008 start_sample  output  1  one-cycle request pulse to the ADC sampler.
REQ-009 sample_done  input  1  one-cycle pulse from the sampler; sample valid in the same cycle.
REQ-010 sample  input  10  unsigned ADC code, 0..1023.
REQ-011 frame_ready  output  1  a complete frame is held in the read bank.
REQ-012 frame_ack  input  1  one-cycle pulse; consumer releases the read bank.
REQ-013 rd_addr  input  ADDR_W  read-bank sample index.
REQ-014 rd_data  output  10  signed sample at rd_addr; 1-cycle latency.
REQ-015 overrun  output  1  one-cycle pulse when a frame is dropped.
REQ-016 missed  output  1  one-cycle pulse when a sample tick is skipped.

Function
REQ-017 Rate counter SHALL count 0..CLK_DIV-1 and wrap while enable=1; it SHALL be held at 0 while enable=0.
REQ-018 Request FSM states are IDLE and WAIT_DONE. At counter terminal count in IDLE: pulse start_sample for one cycle and go to WAIT_DONE.
REQ-019 In WAIT_DONE, sample_done SHALL return the FSM to IDLE. A terminal count in WAIT_DONE SHALL pulse missed and issue no request.
REQ-020 Deasserting enable SHALL NOT abort WAIT_DONE; the in-flight sample is still captured.
REQ-021 sample_done in IDLE SHALL be ignored (no write).
REQ-022 Capture: write {~sample[9], sample[8:0]} (sample minus 512, two's complement) to the write bank at wr_ptr, then increment wr_ptr modulo FRAME_LEN.
REQ-023 Two banks of FRAME_LEN entries each; a bank-select bit identifies the write bank, and the other bank is the read bank.
REQ-024 On the write to index FRAME_LEN-1 with frame_ready=0 (after ack processing): toggle bank-select and set frame_ready=1 next cycle.
REQ-025 On the write to index FRAME_LEN-1 with frame_ready=1: do not swap, pulse overrun, and refill the same write bank from index 0.
REQ-026 frame_ack with frame_ready=1 SHALL clear frame_ready next cycle. frame_ack with frame_ready=0 SHALL be ignored.
REQ-027 If frame_ack and the final write occur in the same cycle, the ack takes precedence: the banks swap, frame_ready stays 1, and no overrun is signalled.
REQ-028 rd_data SHALL be registered from the read bank at rd_addr, valid one cycle after rd_addr. The read bank content SHALL be stable while frame_ready=1.

Reset
REQ-029 Reset SHALL clear start_sample, frame_ready, overrun, missed and rd_data, and set the FSM to IDLE.
REQ-030 Reset SHALL clear rate counter, wr_ptr and bank-select to 0. RAM contents are not reset.
REQ-031 Reset mid-frame SHALL discard the partial frame. A sample_done arriving after reset is ignored (FSM in IDLE).

Structure
REQ-032 Shared package SHALL hold SAMPLE_W=10, MID_CODE=512, and the request FSM state encoding.
REQ-033 Bank storage SHALL be one sub-module, frame_bank_ram: simple dual-port, 2*FRAME_LEN x 10, address = {bank, index}, synchronous read.

Verification
REQ-034 CLK_DIV=16, enable=1, sampler replies 3 cycles after each request: start_sample every 16 cycles, missed never asserted.
REQ-035 Codes 0, 512 and 1023 captured: rd_data reads -512, 0 and +511 at the corresponding indices.
REQ-036 FRAME_LEN=8, fill 8 samples with no ack: frame_ready rises one cycle after the 8th write. Fill 8 more with no ack: overrun pulses once, and read bank data is unchanged.
REQ-037 frame_ack coinciding with the final write of the next frame: swap occurs, frame_ready remains 1, overrun remains 0, and new data is readable.
REQ-038 Sampler withholds sample_done for 40 cycles at CLK_DIV=16: missed pulses twice, and no start_sample while in WAIT_DONE.
REQ-039 rst asserted at wr_ptr=5: all outputs are 0 immediately. After release, the first frame_ready comes only after FRAME_LEN new samples.

Source files
------------

// File: rtl/sample_framer_pkg.sv
// Shared types and constants for the ADC sample framer.
package sample_framer_pkg;

  localparam int unsigned SAMPLE_W = 10;
  localparam int unsigned MID_CODE = 512;

  typedef enum logic {
    IDLE,
    WAIT_DONE
  } req_state_t;

  // Offset-binary to two's complement: subtracting mid-scale flips the MSB.
  function automatic logic [SAMPLE_W-1:0] to_twos(input logic [SAMPLE_W-1:0] code);
    return code - SAMPLE_W'(MID_CODE);
  endfunction

endpackage

// File: rtl/sample_framer_if.sv
// Sampler handshake and frame read-out signals of the sample framer.
interface sample_framer_if #(
  parameter int unsigned ADDR_W = 8
);

  logic                                   enable;
  logic                                   start_sample;
  logic                                   sample_done;
  logic [sample_framer_pkg::SAMPLE_W-1:0] sample;
  logic                                   frame_ready;
  logic                                   frame_ack;
  logic [ADDR_W-1:0]                      rd_addr;
  logic [sample_framer_pkg::SAMPLE_W-1:0] rd_data;
  logic                                   overrun;
  logic                                   missed;

  modport master (
    input  enable, sample_done, sample, frame_ack, rd_addr,
    output start_sample, frame_ready, rd_data, overrun, missed
  );

  modport slave (
    output enable, sample_done, sample, frame_ack, rd_addr,
    input  start_sample, frame_ready, rd_data, overrun, missed
  );

endinterface

// File: rtl/sample_framer_ram.sv
// Ping-pong frame storage: simple dual-port RAM addressed by {bank, index}.
module frame_bank_ram
  import sample_framer_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [ADDR_W:0]     waddr,
  input  logic [SAMPLE_W-1:0] wdata,
  input  logic [ADDR_W:0]     raddr,
  output logic [SAMPLE_W-1:0] rdata
);

  logic [SAMPLE_W-1:0] mem [0:(2**(ADDR_W+1))-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Only the read register is reset; array contents are left as-is.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata <= '0;
    else     rdata <= mem[raddr];
  end

endmodule

// File: rtl/sample_framer.sv
// Paces ADC sample requests and packs captured samples into double-buffered frames.
module sample_framer
  import sample_framer_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 2500,
  parameter int unsigned FRAME_LEN = 256,
  parameter int unsigned ADDR_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  sample_framer_if.master  bus
);

  localparam int unsigned CNT_W = 16;

  logic [CNT_W-1:0]  rate_cnt;
  logic              tick;
  req_state_t        state;
  logic              start_q;
  logic              missed_q;
  logic [ADDR_W-1:0] wr_ptr;
  logic              bank_sel;
  logic              frame_ready_q;
  logic              overrun_q;
  logic              wr_en;
  logic              last_wr;
  logic              ack_ok;

  assign tick    = bus.enable && (rate_cnt == CNT_W'(CLK_DIV - 1));
  assign wr_en   = (state == WAIT_DONE) && bus.sample_done;
  assign last_wr = wr_en && (wr_ptr == ADDR_W'(FRAME_LEN - 1));
  assign ack_ok  = bus.frame_ack && frame_ready_q;

  assign bus.start_sample = start_q;
  assign bus.missed       = missed_q;
  assign bus.frame_ready  = frame_ready_q;
  assign bus.overrun      = overrun_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      rate_cnt <= '0;
    else if (!bus.enable || tick) rate_cnt <= '0;
    else                          rate_cnt <= rate_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      start_q  <= 1'b0;
      missed_q <= 1'b0;
    end else begin
      start_q  <= 1'b0;
      missed_q <= 1'b0;
      case (state)
        IDLE: begin
          if (tick) begin
            start_q <= 1'b1;
            state   <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (tick)            missed_q <= 1'b1;
          if (bus.sample_done) state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Ack is applied first so a coincident final write sees the bank as free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr        <= '0;
      bank_sel      <= 1'b0;
      frame_ready_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      if (ack_ok) frame_ready_q <= 1'b0;
      if (wr_en) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
        if (last_wr) begin
          if (!frame_ready_q || ack_ok) begin
            bank_sel      <= ~bank_sel;
            frame_ready_q <= 1'b1;
          end else begin
            overrun_q <= 1'b1;
          end
        end
      end
    end
  end

  frame_bank_ram #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_en),
    .waddr ({bank_sel, wr_ptr}),
    .wdata (to_twos(bus.sample)),
    .raddr ({~bank_sel, bus.rd_addr}),
    .rdata (bus.rd_data)
  );

endmodule

// File: tb/tb_sample_framer.sv
// Randomized bench for sample_framer against a frame-level reference model.
module tb_sample_framer;

  localparam int unsigned CLK_DIV   = 16;
  localparam int unsigned FRAME_LEN = 8;
  localparam int unsigned ADDR_W    = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sample_framer_if #(.ADDR_W(ADDR_W)) bus();

  sample_framer #(
    .CLK_DIV   (CLK_DIV),
    .FRAME_LEN (FRAME_LEN),
    .ADDR_W    (ADDR_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Reference model state: ticks since enable, outstanding request, frames as queues.
  int m_cnt;
  bit m_busy, m_ready, m_rd_valid;
  int cur[$];
  int m_read[FRAME_LEN];

  // Stimulus controls
  int reply_cnt   = 0;
  int reply_delay = 3;
  bit reply_rand  = 0;
  bit en          = 1;
  int forced[$];
  int ack_mode    = 0;
  bit stray_en    = 0;
  bit en_toggle   = 0;
  bit period_chk  = 0;

  int cyc = 0, last_start = -1, rd_ptr = 0;
  int obs_start = 0, obs_missed = 0, obs_over = 0, cap_total = 0, hits = 0;

  task automatic model_reset();
    m_cnt = 0; m_busy = 0; m_ready = 0; m_rd_valid = 0;
    cur.delete();
  endtask

  task automatic step();
    bit sd, ack, tick, cap, ack_eff, rd_chk, e_start, e_missed, e_over;
    int code, rd_exp;
    logic [ADDR_W-1:0] ra;

    sd = 0;
    if (reply_cnt > 0) begin
      reply_cnt--;
      sd = (reply_cnt == 0);
    end
    if (!sd && stray_en && !m_busy && $urandom_range(0, 11) == 0) sd = 1;
    code = $urandom_range(0, 1023);
    if (sd && m_busy && forced.size() > 0) code = forced.pop_front();
    case (ack_mode)
      1:       ack = sd && m_busy && m_ready && (cur.size() == FRAME_LEN - 1);
      2:       ack = ($urandom_range(0, m_ready ? 7 : 31) == 0);
      default: ack = 0;
    endcase
    if (en_toggle && $urandom_range(0, 39) == 0) en = !en;
    ra = ADDR_W'(rd_ptr % FRAME_LEN);
    rd_ptr++;

    bus.enable      = en;
    bus.sample_done = sd;
    bus.sample      = 10'(code);
    bus.frame_ack   = ack;
    bus.rd_addr     = ra;

    rd_chk = m_rd_valid;
    rd_exp = m_read[ra];

    tick  = en && (m_cnt == CLK_DIV - 1);
    m_cnt = (en && !tick) ? m_cnt + 1 : 0;
    cap   = m_busy && sd;
    e_start  = tick && !m_busy;
    e_missed = tick && m_busy;
    if (!m_busy) m_busy = tick;
    else if (sd) m_busy = 0;
    if (e_start) reply_cnt = reply_rand ? $urandom_range(1, 20) : reply_delay;

    ack_eff = ack && m_ready;
    e_over  = 0;
    if (ack_eff) m_ready = 0;
    if (cap) begin
      cap_total++;
      cur.push_back(code - 512);
      if (cur.size() == FRAME_LEN) begin
        if (!m_ready) begin
          foreach (m_read[i]) m_read[i] = cur[i];
          m_ready    = 1;
          m_rd_valid = 1;
          if (ack_eff) hits++;
        end else begin
          e_over = 1;
        end
        cur.delete();
      end
    end

    @(posedge clk);
    #1;
    cyc++;
    check("start_sample", bus.start_sample, e_start);
    check("missed", bus.missed, e_missed);
    check("overrun", bus.overrun, e_over);
    check("frame_ready", bus.frame_ready, m_ready);
    if (rd_chk) check("rd_data", int'($signed(bus.rd_data)), rd_exp);
    if (bus.start_sample) begin
      obs_start++;
      if (period_chk && last_start >= 0) check("start_period", cyc - last_start, CLK_DIV);
      last_start = cyc;
    end
    if (bus.missed)  obs_missed++;
    if (bus.overrun) obs_over++;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_start_sample"}, bus.start_sample, 0);
    check({tag, "_frame_ready"},  bus.frame_ready,  0);
    check({tag, "_overrun"},      bus.overrun,      0);
    check({tag, "_missed"},       bus.missed,       0);
    check({tag, "_rd_data"},      int'(bus.rd_data), 0);
  endtask

  int snap_a, snap_b;

  initial begin
    bus.enable = 0; bus.sample_done = 0; bus.sample = '0; bus.frame_ack = 0; bus.rd_addr = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 0;

    // Steady pacing, reply after 3 cycles, mid/extreme codes at the start of the frame.
    forced = '{0, 512, 1023};
    period_chk = 1;
    for (int i = 0; i < 300 && !m_ready; i++) step();
    check("first_frame_ready", bus.frame_ready, 1);
    snap_a = obs_over;
    snap_b = cap_total;
    for (int i = 0; i < 300 && cap_total < snap_b + FRAME_LEN; i++) step();
    repeat (2) step();
    check("overrun_pulses", obs_over - snap_a, 1);
    check("missed_steady", obs_missed, 0);
    period_chk = 0;

    // Ack lands on the final write of the next frame.
    ack_mode = 1;
    for (int i = 0; i < 400 && hits == 0; i++) step();
    if (hits == 0) check("coincide_timeout", hits, 1);
    check("coincide_ready", bus.frame_ready, 1);
    check("coincide_overrun", bus.overrun, 0);
    repeat (FRAME_LEN) step();
    ack_mode = 0;

    // Sampler stalls for 40 cycles.
    reply_delay = 40;
    snap_a = obs_start;
    for (int i = 0; i < 40 && obs_start == snap_a; i++) step();
    check("stall_request_seen", obs_start - snap_a, 1);
    reply_delay = 3;
    snap_a = obs_missed;
    snap_b = obs_start;
    repeat (44) step();
    check("stall_missed", obs_missed - snap_a, 2);
    check("stall_no_request", obs_start - snap_b, 0);
    repeat (20) step();

    // Random acks, stray done pulses, enable toggling, variable reply latency.
    ack_mode = 2; stray_en = 1; en_toggle = 1; reply_rand = 1;
    repeat (1500) step();

    // Reset mid-frame.
    ack_mode = 0; stray_en = 0; en_toggle = 0; reply_rand = 0; en = 1;
    for (int i = 0; i < 400 && cur.size() != 5; i++) step();
    check("pre_reset_wr_ptr5", cur.size(), 5);
    #2;
    rst = 1;
    #1;
    check_reset_outputs("async_reset");
    model_reset();
    reply_cnt = 2;
    last_start = -1;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    snap_b = cap_total;
    for (int i = 0; i < 300 && !m_ready; i++) step();
    check("post_reset_ready", bus.frame_ready, 1);
    check("post_reset_samples", cap_total - snap_b, FRAME_LEN);
    repeat (40) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
